alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port round-robin front end to a single 8-bit ALU.
//   clk, rst            : rising-edge clock, asynchronous active-high reset
//   reqN_valid/ready    : per-requester handshake (ready is combinational, IDLE only)
//   reqN_op/a/b         : opcode and operands of requester N
//   rsp_valid/ready     : response handshake; rsp_id names the owning requester
//   rsp_y, rsp_zero,
//   rsp_carry, rsp_borrow : registered result and flags
//   busy                : FSM is outside IDLE
// alu8 is the team 8-bit ALU: combinational, raw carry/borrow only on arithmetic ops.

module alu8 (
  input  logic [3:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y,
  output logic       carry,
  output logic       borrow
);
  logic [8:0] wide;
  logic [2:0] sh;

  always_comb begin
    wide   = '0;
    y      = '0;
    carry  = 1'b0;
    borrow = 1'b0;
    sh     = b[2:0];
    case (op)
      4'd0:  begin wide = {1'b0, a} + {1'b0, b}; y = wide[7:0]; carry  = wide[8]; end
      4'd1:  begin wide = {1'b0, a} - {1'b0, b}; y = wide[7:0]; borrow = wide[8]; end
      4'd2:  begin wide = {1'b0, a} + 9'd1;      y = wide[7:0]; carry  = wide[8]; end
      4'd3:  begin wide = {1'b0, a} - 9'd1;      y = wide[7:0]; borrow = wide[8]; end
      4'd4:  y = a & b;
      4'd5:  y = a | b;
      4'd6:  y = a ^ b;
      4'd7:  y = ~a;
      4'd8:  y = ~(a | b);
      4'd9:  y = ~(a ^ b);
      4'd10: y = ~(a & b);
      4'd11: y = a << sh;
      4'd12: y = a >> sh;
      4'd13: y = 8'($signed(a) >>> sh);
      4'd14: y = (a << sh) | (a >> (4'd8 - {1'b0, sh}));
      4'd15: y = (a >> sh) | (a << (4'd8 - {1'b0, sh}));
    endcase
  end
endmodule

module alu_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_op,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_op,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_y,
  output logic       rsp_zero,
  output logic       rsp_carry,
  output logic       rsp_borrow,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic [3:0] op_q, op_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic       id_q, id_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       rsp_id_q, rsp_id_d;
  logic [7:0] rsp_y_q, rsp_y_d;
  logic       rsp_zero_q, rsp_zero_d;
  logic       rsp_carry_q, rsp_carry_d;
  logic       rsp_borrow_q, rsp_borrow_d;

  logic       grant0, grant1;
  logic [7:0] alu_y;
  logic       alu_carry, alu_borrow;

  alu8 u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .y      (alu_y),
    .carry  (alu_carry),
    .borrow (alu_borrow)
  );

  always_comb begin
    // On a tie the port not granted last wins; last_grant_q == 1 favours port 0.
    grant0 = req0_valid & (~req1_valid | last_grant_q);
    grant1 = req1_valid & (~req0_valid | ~last_grant_q);
    // rst gates ready so nothing looks accepted while reset is held.
    req0_ready = (state_q == IDLE) & grant0 & ~rst;
    req1_ready = (state_q == IDLE) & grant1 & ~rst;

    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_y_d      = rsp_y_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_borrow_d = rsp_borrow_q;

    case (state_q)
      IDLE: begin
        if (grant0 | grant1) begin
          state_d      = EXEC;
          id_d         = grant1;
          last_grant_d = grant1;
          op_d         = grant1 ? req1_op : req0_op;
          a_d          = grant1 ? req1_a  : req0_a;
          b_d          = grant1 ? req1_b  : req0_b;
        end
      end
      EXEC: begin
        state_d      = RESP;
        rsp_valid_d  = 1'b1;
        rsp_id_d     = id_q;
        rsp_y_d      = alu_y;
        rsp_zero_d   = (alu_y == 8'h00);
        rsp_carry_d  = alu_carry  & ((op_q == 4'd0) | (op_q == 4'd2));
        rsp_borrow_d = alu_borrow & ((op_q == 4'd1) | (op_q == 4'd3));
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_y_q      <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_carry_q  <= 1'b0;
      rsp_borrow_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_y_q      <= rsp_y_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_borrow_q <= rsp_borrow_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_y      = rsp_y_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_carry  = rsp_carry_q;
  assign rsp_borrow = rsp_borrow_q;
  assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_op, req1_op;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [7:0] rsp_y;
  logic       rsp_zero, rsp_carry, rsp_borrow, busy;

  typedef struct packed {
    logic       id;
    logic [7:0] y;
    logic       z;
    logic       c;
    logic       b;
  } rsp_t;

  rsp_t sb[$];
  rsp_t sb_exp;
  int   grant_id[$];
  int   grant_cyc[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  alu_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_y      (rsp_y),
    .rsp_zero   (rsp_zero),
    .rsp_carry  (rsp_carry),
    .rsp_borrow (rsp_borrow),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic rsp_t model(input logic id, input logic [3:0] op,
                                 input logic [7:0] a, input logic [7:0] b);
    logic [8:0]  w;
    logic [15:0] d;
    logic [2:0]  s;
    rsp_t        r;
    s = b[2:0];
    w = '0;
    d = {a, a};
    r = '0;
    r.id = id;
    case (op)
      4'd0:  begin w = {1'b0, a} + {1'b0, b}; r.y = w[7:0]; r.c = w[8]; end
      4'd1:  begin w = {1'b0, a} - {1'b0, b}; r.y = w[7:0]; r.b = w[8]; end
      4'd2:  begin w = {1'b0, a} + 9'd1;      r.y = w[7:0]; r.c = w[8]; end
      4'd3:  begin w = {1'b0, a} - 9'd1;      r.y = w[7:0]; r.b = w[8]; end
      4'd4:  r.y = a & b;
      4'd5:  r.y = a | b;
      4'd6:  r.y = a ^ b;
      4'd7:  r.y = ~a;
      4'd8:  r.y = ~(a | b);
      4'd9:  r.y = ~(a ^ b);
      4'd10: r.y = ~(a & b);
      4'd11: r.y = a << s;
      4'd12: r.y = a >> s;
      4'd13: r.y = 8'($signed(a) >>> s);
      4'd14: begin d = d << s; r.y = d[15:8]; end
      4'd15: begin d = d >> s; r.y = d[7:0]; end
    endcase
    r.z = (r.y == 8'h00);
    return r;
  endfunction

  // Scoreboard consumer: a response handshake completes on the coming edge.
  always @(negedge clk) begin
    #3;
    if (!rst && rsp_valid && rsp_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got id=%0d y=%h with no pending expectation", rsp_id, rsp_y);
      end else begin
        sb_exp = sb.pop_front();
        if ({rsp_id, rsp_y, rsp_zero, rsp_carry, rsp_borrow} !== sb_exp) begin
          failures++;
          $display("FAIL sb_rsp: got id=%0d y=%h z=%0d c=%0d b=%0d, exp id=%0d y=%h z=%0d c=%0d b=%0d",
                   rsp_id, rsp_y, rsp_zero, rsp_carry, rsp_borrow,
                   sb_exp.id, sb_exp.y, sb_exp.z, sb_exp.c, sb_exp.b);
        end
      end
    end
  end

  // Scoreboard producer: a ready seen now means acceptance on the coming edge.
  task automatic advance();
    #1;
    if (!rst && req0_ready) begin
      sb.push_back(model(1'b0, req0_op, req0_a, req0_b));
      grant_id.push_back(0);
      grant_cyc.push_back(cyc);
    end
    if (!rst && req1_ready) begin
      sb.push_back(model(1'b1, req1_op, req1_a, req1_b));
      grant_id.push_back(1);
      grant_cyc.push_back(cyc);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    advance();
    advance();
    rst = 1'b0;
    sb.delete();
    grant_id.delete();
    grant_cyc.delete();
  endtask

  task automatic issue(input logic port, input logic [3:0] op,
                       input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    if (port) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end
    #1;
    while (!(port ? req1_ready : req0_ready) && n < 20) begin
      advance();
      n++;
      #1;
    end
    if (n == 20) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout: port %0d never saw ready, required ready=1", port);
    end
    advance();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    #1;
    while (!rsp_valid && n < 10) begin
      advance();
      n++;
      #1;
    end
    if (!rsp_valid) begin
      checks++;
      failures++;
      $display("FAIL rsp_timeout: rsp_valid=%0d, required 1", rsp_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rsp_ready = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_op = 4'd4; req0_a = 8'h3C; req0_b = 8'h0F;
    req1_op = 4'd5; req1_a = 8'h11; req1_b = 8'h22;
    #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_zero, rsp_carry, rsp_borrow, busy, req0_ready, req1_ready} !== 8'h00) begin
      failures++;
      $display("FAIL reset_ctrl: got v=%0d id=%0d z=%0d c=%0d b=%0d busy=%0d r0=%0d r1=%0d, required all 0",
               rsp_valid, rsp_id, rsp_zero, rsp_carry, rsp_borrow, busy, req0_ready, req1_ready);
    end
    checks++;
    if (rsp_y !== 8'h00) begin
      failures++;
      $display("FAIL reset_y: got %h, required 00", rsp_y);
    end
    advance();
    advance();
    rst = 1'b0;
    sb.delete();
    grant_id.delete();
    grant_cyc.delete();
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      failures++;
      $display("FAIL reset_first_tie: got r0=%0d r1=%0d, required r0=1 r1=0", req0_ready, req1_ready);
    end
    advance();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (4) advance();
  endtask

  task automatic test_single_add();
    apply_reset();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 4'd0; req0_a = 8'hF0; req0_b = 8'h20;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      failures++;
      $display("FAIL add_ready: got r0=%0d r1=%0d, required r0=1 r1=0", req0_ready, req1_ready);
    end
    advance();
    req0_valid = 1'b0;
    #1;
    checks++;
    if ({req0_ready, busy, rsp_valid} !== 3'b010) begin
      failures++;
      $display("FAIL add_exec: got r0=%0d busy=%0d v=%0d, required r0=0 busy=1 v=0", req0_ready, busy, rsp_valid);
    end
    advance();
    #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_y, rsp_zero, rsp_carry, rsp_borrow} !== {1'b1, 1'b0, 8'h10, 1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL add_rsp: got v=%0d id=%0d y=%h z=%0d c=%0d b=%0d, required v=1 id=0 y=10 z=0 c=1 b=0",
               rsp_valid, rsp_id, rsp_y, rsp_zero, rsp_carry, rsp_borrow);
    end
    advance();
    #1;
    checks++;
    if ({rsp_valid, busy} !== 2'b00) begin
      failures++;
      $display("FAIL add_done: got v=%0d busy=%0d, required 0 0", rsp_valid, busy);
    end
    advance();
  endtask

  task automatic test_round_robin();
    int n = 0;
    int exp_id[4] = '{0, 1, 0, 1};
    apply_reset();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 4'd0; req0_a = 8'h01; req0_b = 8'h02;
    req1_valid = 1'b1; req1_op = 4'd1; req1_a = 8'h07; req1_b = 8'h03;
    while (grant_id.size() < 4 && n < 40) begin
      advance();
      n++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    checks++;
    if (grant_id.size() < 4) begin
      failures++;
      $display("FAIL rr_count: got %0d grants, required 4", grant_id.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (grant_id[i] !== exp_id[i]) begin
          failures++;
          $display("FAIL rr_order[%0d]: got port %0d, required %0d", i, grant_id[i], exp_id[i]);
        end
      end
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (grant_cyc[i] - grant_cyc[i-1] !== 3) begin
          failures++;
          $display("FAIL rr_interval[%0d]: got %0d cycles, required 3", i, grant_cyc[i] - grant_cyc[i-1]);
        end
      end
    end
    repeat (4) advance();
  endtask

  task automatic test_flags();
    apply_reset();
    rsp_ready = 1'b1;
    issue(1'b1, 4'd1, 8'h05, 8'h05);
    wait_rsp();
    checks++;
    if ({rsp_id, rsp_y, rsp_zero, rsp_carry, rsp_borrow} !== {1'b1, 8'h00, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL flags_sub: got id=%0d y=%h z=%0d c=%0d b=%0d, required id=1 y=00 z=1 c=0 b=0",
               rsp_id, rsp_y, rsp_zero, rsp_carry, rsp_borrow);
    end
    advance();
    issue(1'b1, 4'd6, 8'hFF, 8'hFF);
    wait_rsp();
    checks++;
    if ({rsp_id, rsp_y, rsp_zero, rsp_carry, rsp_borrow} !== {1'b1, 8'h00, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL flags_xor: got id=%0d y=%h z=%0d c=%0d b=%0d, required id=1 y=00 z=1 c=0 b=0",
               rsp_id, rsp_y, rsp_zero, rsp_carry, rsp_borrow);
    end
    advance();
    issue(1'b1, 4'd3, 8'h00, 8'h00);
    wait_rsp();
    checks++;
    if ({rsp_id, rsp_y, rsp_zero, rsp_carry, rsp_borrow} !== {1'b1, 8'hFF, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL flags_dec: got id=%0d y=%h z=%0d c=%0d b=%0d, required id=1 y=ff z=0 c=0 b=1",
               rsp_id, rsp_y, rsp_zero, rsp_carry, rsp_borrow);
    end
    advance();
    issue(1'b0, 4'd2, 8'hFF, 8'h00);
    wait_rsp();
    checks++;
    if ({rsp_id, rsp_y, rsp_zero, rsp_carry, rsp_borrow} !== {1'b0, 8'h00, 1'b1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL flags_inc: got id=%0d y=%h z=%0d c=%0d b=%0d, required id=0 y=00 z=1 c=1 b=0",
               rsp_id, rsp_y, rsp_zero, rsp_carry, rsp_borrow);
    end
    advance();
  endtask

  task automatic test_shift();
    apply_reset();
    rsp_ready = 1'b1;
    issue(1'b0, 4'd15, 8'h81, 8'h09);
    wait_rsp();
    checks++;
    if ({rsp_id, rsp_y, rsp_zero, rsp_carry, rsp_borrow} !== {1'b0, 8'hC0, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL shift_ror: got id=%0d y=%h z=%0d c=%0d b=%0d, required id=0 y=c0 z=0 c=0 b=0",
               rsp_id, rsp_y, rsp_zero, rsp_carry, rsp_borrow);
    end
    advance();
    issue(1'b1, 4'd13, 8'h80, 8'h03);
    wait_rsp();
    checks++;
    if (rsp_y !== 8'hF0) begin
      failures++;
      $display("FAIL shift_sra: got y=%h, required f0", rsp_y);
    end
    advance();
  endtask

  task automatic test_backpressure();
    apply_reset();
    rsp_ready = 1'b0;
    req1_op = 4'd6; req1_a = 8'h5A; req1_b = 8'h0F;
    issue(1'b0, 4'd0, 8'h03, 8'h04);
    wait_rsp();
    for (int i = 0; i < 5; i++) begin
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      checks++;
      if ({rsp_valid, rsp_id, rsp_y, rsp_zero, rsp_carry, rsp_borrow, busy, req0_ready, req1_ready}
          !== {1'b1, 1'b0, 8'h07, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got v=%0d id=%0d y=%h z=%0d c=%0d b=%0d busy=%0d r0=%0d r1=%0d, required v=1 id=0 y=07 flags=0 busy=1 r=0",
                 i, rsp_valid, rsp_id, rsp_y, rsp_zero, rsp_carry, rsp_borrow, busy, req0_ready, req1_ready);
      end
      advance();
    end
    rsp_ready = 1'b1;
    advance();
    #1;
    checks++;
    if ({rsp_valid, busy, req0_ready, req1_ready} !== 4'b0001) begin
      failures++;
      $display("FAIL bp_release: got v=%0d busy=%0d r0=%0d r1=%0d, required v=0 busy=0 r0=0 r1=1",
               rsp_valid, busy, req0_ready, req1_ready);
    end
    advance();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_rsp();
    advance();
    #1;
    checks++;
    if (sb.size() !== 0) begin
      failures++;
      $display("FAIL bp_drain: got %0d pending, required 0", sb.size());
    end
    advance();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    rsp_ready = 1'b1;
    issue(1'b0, 4'd0, 8'h01, 8'h01);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_y, rsp_zero, rsp_carry, rsp_borrow, busy, req0_ready, req1_ready} !== '0) begin
      failures++;
      $display("FAIL midrst_outputs: got v=%0d id=%0d y=%h z=%0d c=%0d b=%0d busy=%0d, required all 0",
               rsp_valid, rsp_id, rsp_y, rsp_zero, rsp_carry, rsp_borrow, busy);
    end
    advance();
    rst = 1'b0;
    sb.delete();
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if ({rsp_valid, busy} !== 2'b00) begin
        failures++;
        $display("FAIL midrst_after[%0d]: got v=%0d busy=%0d, required 0 0", i, rsp_valid, busy);
      end
      advance();
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 60; i++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_op = 4'($urandom_range(0, 15)); req0_a = 8'($urandom); req0_b = 8'($urandom);
      req1_op = 4'($urandom_range(0, 15)); req1_a = 8'($urandom); req1_b = 8'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      advance();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (6) advance();
    #1;
    checks++;
    if (sb.size() !== 0) begin
      failures++;
      $display("FAIL random_drain: got %0d pending, required 0", sb.size());
    end
    advance();
  endtask

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = '0; req0_a = '0; req0_b = '0;
    req1_op = '0; req1_a = '0; req1_b = '0;
    @(negedge clk);
    test_reset();
    test_single_add();
    test_round_robin();
    test_flags();
    test_shift();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
